// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the alu arbiter slice: operand width, opcodes,
// FSM state encodings and the round-robin pick helper.
package alu_arbiter_pkg;

  localparam int ALU_WIDTH = 32;

  // Opcodes understood by the shared alu
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  // Arbiter FSM encodings; 2'b11 is unused and recovers to IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Winner of the two request lines: the only valid port, or the port that
  // did not win last time when both are valid.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
    if (valid == 2'b11) return ~last_grant;
    return valid[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit alu shared by both arbiter ports. Overflow is the
// signed overflow of ADD/SUB and reads 0 for every other opcode.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_lt   = $signed(i_a) < $signed(i_b);

  // Select the result and overflow flag for the current opcode
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result   = w_sum;
        o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        o_result   = w_diff;
        o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt};
      OP_AND:  o_result = i_a & i_b;
      OP_NAND: o_result = ~(i_a & i_b);
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_OR:   o_result = i_a | i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared alu. One operation is in
// flight at a time: IDLE accepts, EXEC drives the alu from registered
// operands and captures its output, RESP holds the tagged result until the
// consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             busy
);

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_overflow;

  logic             w_grant_id;
  logic             w_handshake;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_overflow;

  assign w_grant_id = rr_pick(req_valid, r_last_grant);

  // Offer ready only to the winner, only in IDLE and never while reset is high
  always_comb begin
    req_ready = 2'b00;
    if (r_state == ST_IDLE && !reset && req_valid != 2'b00) begin
      req_ready = w_grant_id ? 2'b10 : 2'b01;
    end
  end

  assign w_handshake = |(req_valid & req_ready);

  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_result   (w_alu_result),
    .o_overflow (w_alu_overflow)
  );

  // Arbiter FSM: accept, execute, hold the response until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= ~RR_INIT;
      // NOTE: operand registers are cleared too, so the alu never sees stale data after reset.
      r_op           <= OP_ADD;
      r_a            <= '0;
      r_b            <= '0;
      r_id           <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_op         <= w_grant_id ? req_op1 : req_op0;
            r_a          <= w_grant_id ? req_a1  : req_a0;
            r_b          <= w_grant_id ? req_b1  : req_b0;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result   <= w_alu_result;
          r_rsp_overflow <= w_alu_overflow;
          r_rsp_id       <= r_id;
          r_rsp_valid    <= 1'b1;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_rsp_result;
  assign rsp_overflow = r_rsp_overflow;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a negedge monitor pushes modelled
// results on every request handshake and pops/compares on every response.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_overflow, busy;
  logic [31:0] rsp_result;

  alu_arbiter #(.WIDTH(32), .RR_INIT(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op0      (req_op0),
    .req_op1      (req_op1),
    .req_a0       (req_a0),
    .req_a1       (req_a1),
    .req_b0       (req_b0),
    .req_b1       (req_b1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference alu written from the opcode table using 64-bit signed arithmetic
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint t = 0;
    o = 1'b0;
    r = 32'h0;
    case (op)
      OP_ADD:  begin t = sa + sbv; r = t[31:0]; o = (t[63:31] != {33{t[31]}}); end
      OP_SUB:  begin t = sa - sbv; r = t[31:0]; o = (t[63:31] != {33{t[31]}}); end
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = (sa < sbv) ? 32'd1 : 32'd0;
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = a | b;
    endcase
  endfunction

  // Scoreboard monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_onehot", {31'b0, req_ready == 2'b11}, 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          exp_t e;
          e.id = p[0];
          if (p == 0) model(req_op0, req_a0, req_b0, e.res, e.ovf);
          else        model(req_op1, req_a1, req_b1, e.res, e.ovf);
          sb.push_back(e);
          grant_log.push_back(p);
          grant_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id",  {31'b0, rsp_id}, {31'b0, e.id});
          check("rsp_res", rsp_result, e.res);
          check("rsp_ovf", {31'b0, rsp_overflow}, {31'b0, e.ovf});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op on port p until accepted, then drop valid (ends in EXEC)
  task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    if (p == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
    req_valid[p] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    req_valid[p] = 1'b0;
    if (!ok) check("issue_timeout", 32'd1, 32'd0);
  endtask

  // Wait until every expected response has been consumed and the DUT is idle
  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 32'd1, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=hang want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b1;
    req_op0 = OP_ADD; req_a0 = 32'd9; req_b0 = 32'd9;
    req_op1 = OP_ADD; req_a1 = 32'd9; req_b1 = 32'd9;
    req_valid = 2'b11;
    repeat (2) @(posedge clk);

    // Reset state; ready must stay low even with both ports valid
    @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_id",    {31'b0, rsp_id}, 32'd0);
    check("rst_result",    rsp_result, 32'd0);
    check("rst_ovf",       {31'b0, rsp_overflow}, 32'd0);
    check("rst_busy",      {31'b0, busy}, 32'd0);
    check("rst_ready",     {30'b0, req_ready}, 32'd0);
    tick();
    req_valid = 2'b00;
    reset = 1'b0;
    tick();

    // Port0 ADD 2+1: ready in the same cycle, response two cycles later
    req_op0 = OP_ADD; req_a0 = 32'd2; req_b0 = 32'd1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("t1_ready", {30'b0, req_ready}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_exec_valid", {31'b0, rsp_valid}, 32'd0);
    check("t1_exec_busy",  {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("t1_result",    rsp_result, 32'd3);
    check("t1_ovf",       {31'b0, rsp_overflow}, 32'd0);
    check("t1_id",        {31'b0, rsp_id}, 32'd0);
    tick();
    drain();

    // Port1 SUB overflow under 4 cycles of backpressure; port0 blips valid meanwhile
    rsp_ready = 1'b0;
    issue(1, OP_SUB, 32'h8000_0000, 32'd1);
    tick();
    req_op0 = OP_OR; req_a0 = 32'h1234; req_b0 = 32'h1;
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = (i == 0);
      @(negedge clk);
      check($sformatf("t2_valid%0d", i),  {31'b0, rsp_valid}, 32'd1);
      check($sformatf("t2_result%0d", i), rsp_result, 32'h7FFF_FFFF);
      check($sformatf("t2_ovf%0d", i),    {31'b0, rsp_overflow}, 32'd1);
      check($sformatf("t2_id%0d", i),     {31'b0, rsp_id}, 32'd1);
      check($sformatf("t2_ready%0d", i),  {30'b0, req_ready}, 32'd0);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    drain();

    // Both ports valid every cycle: grants alternate starting at port0, 3 cycles apart
    grant_log.delete();
    grant_cyc.delete();
    req_op0 = OP_ADD; req_a0 = 32'd5;         req_b0 = 32'd7;
    req_op1 = OP_SLT; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1;
    req_valid = 2'b11;
    for (int k = 0; k < 40 && grant_log.size() < 4; k++) tick();
    req_valid = 2'b00;
    check("t3_grants", grant_log.size(), 32'd4);
    for (int j = 0; j < grant_log.size() && j < 4; j++) begin
      check($sformatf("t3_grant%0d", j), grant_log[j], j % 2);
      if (j > 0) check($sformatf("t3_gap%0d", j), grant_cyc[j] - grant_cyc[j-1], 32'd3);
    end
    drain();

    // Logic ops; the result register keeps its value after the handshake
    issue(0, OP_NAND, 32'hFFFF_0000, 32'h0F0F_0F0F);
    drain();
    check("t4_nand", rsp_result, 32'hF0F0_FFFF);  // ~(0xFFFF0000 & 0x0F0F0F0F)
    issue(1, OP_NOR, 32'd0, 32'd0);
    drain();
    check("t4_nor", rsp_result, 32'hFFFF_FFFF);
    check("t4_nor_id", {31'b0, rsp_id}, 32'd1);
    issue(0, OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    drain();
    check("t4_xor", rsp_result, 32'd0);

    // Reset during EXEC discards the op and restores round-robin priority
    issue(0, OP_AND, 32'hFF, 32'h0F);
    reset = 1'b1;
    @(negedge clk);
    check("t5_ready_in_rst", {30'b0, req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t5_busy",  {31'b0, busy}, 32'd0);
    check("t5_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    repeat (3) begin
      @(negedge clk);
      check("t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    grant_log.delete();
    grant_cyc.delete();
    req_op0 = OP_ADD; req_a0 = 32'd5;         req_b0 = 32'd7;
    req_op1 = OP_SLT; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1;
    req_valid = 2'b11;
    for (int k = 0; k < 20 && grant_log.size() < 1; k++) tick();
    req_valid = 2'b00;
    check("t5_grants", grant_log.size(), 32'd1);
    if (grant_log.size() > 0) check("t5_first_grant", grant_log[0], 32'd0);
    drain();

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
